// File: rtl/otp_keystream_gen.sv
// otp_keystream_gen: Fibonacci LFSR keystream generator. Output bits are packed LSB-first
// into OUT_W-bit words and delivered on a valid/ready handshake.
// Latency: the first word becomes valid OUT_W edges after seed_load (enable=1, no stall).
// Backpressure: the final bit of a word is held back while an undelivered word blocks the slot.
// Optional delivered-word counter: define OTP_KS_COUNT_EN to build words_out.
module otp_keystream_gen #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = 16'h002D,
  parameter int              OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  output logic [OUT_W-1:0] ks_data,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [WIDTH-1:0] lfsr_state,
  output logic             lock_err,
  output logic [31:0]      words_out
);

  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_W - 1);

  // Reject configurations the datapath cannot implement.
  if (TAPS[0] != 1'b1) begin : g_taps_chk
    $error("otp_keystream_gen: TAPS[0] must be 1");
  end
  if (WIDTH < 4) begin : g_width_chk
    $error("otp_keystream_gen: WIDTH must be at least 4");
  end
  if ((OUT_W < 1) || (OUT_W > 32)) begin : g_outw_chk
    $error("otp_keystream_gen: OUT_W must be in 1..32");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [OUT_W-1:0] packer;
  logic [CNT_W-1:0] bit_cnt;

  logic             fb;
  logic             out_bit;
  logic             last_bit;
  logic             handshake;
  logic             stall;
  logic             step;
  logic [OUT_W-1:0] word_next;

  assign fb        = ^(lfsr & TAPS);
  assign out_bit   = lfsr[0];
  assign last_bit  = (bit_cnt == LAST_CNT);
  assign handshake = ks_valid && ks_ready;
  // The last bit of a word may only be taken when the output slot is free or draining now.
  assign stall     = last_bit && ks_valid && !ks_ready;
  assign step      = (state == ST_RUN) && enable && !stall;

  // Packer contents with the current output bit dropped into its LSB-first slot.
  always_comb begin
    word_next          = packer;
    word_next[bit_cnt] = out_bit;
  end

  // Control FSM plus LFSR, packer and output word; seed_load overrides everything but reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      lfsr     <= '0;
      packer   <= '0;
      bit_cnt  <= '0;
      ks_data  <= '0;
      ks_valid <= 1'b0;
      lock_err <= 1'b0;
    end else if (seed_load) begin
      lfsr     <= seed;
      packer   <= '0;
      bit_cnt  <= '0;
      ks_valid <= 1'b0;
      if (seed == '0) begin
        state    <= ST_LOCK;
        lock_err <= 1'b1;
      end else begin
        state    <= ST_RUN;
        lock_err <= 1'b0;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (step) begin
            lfsr <= {fb, lfsr[WIDTH-1:1]};
            if (last_bit) begin
              ks_data <= word_next;
              packer  <= '0;
              bit_cnt <= '0;
            end else begin
              packer  <= word_next;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_IDLE, ST_LOCK: begin
          // Parked until the next seed_load; only the handshake below is active.
          state <= state;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (step && last_bit) begin
        ks_valid <= 1'b1;
      end else if (handshake) begin
        ks_valid <= 1'b0;
      end
    end
  end

  assign lfsr_state = lfsr;

`ifdef OTP_KS_COUNT_EN
  logic [31:0] word_cnt;

  // Count delivered words; a reseed starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt <= '0;
    end else if (seed_load) begin
      word_cnt <= '0;
    end else if (handshake) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end

  assign words_out = word_cnt;
`else
  assign words_out = '0;
`endif

endmodule

// File: tb/tb_otp_keystream_gen.sv
module tb_otp_keystream_gen;

  localparam int         W    = 8;
  localparam int         OW   = 8;
  localparam logic [7:0] TAPS = 8'h03;
`ifdef OTP_KS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          seed_load;
  logic [W-1:0]  seed;
  logic          enable;
  logic [OW-1:0] ks_data;
  logic          ks_valid;
  logic          ks_ready;
  logic [W-1:0]  lfsr_state;
  logic          lock_err;
  logic [31:0]   words_out;

  int checks = 0;
  int errors = 0;

  otp_keystream_gen #(.WIDTH(W), .TAPS(TAPS), .OUT_W(OW)) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed), .enable(enable),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .lfsr_state(lfsr_state), .lock_err(lock_err), .words_out(words_out)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=idle 1=run 2=lock; partial word kept as a queue of bits.
  int          m_mode;
  logic [7:0]  m_lfsr;
  bit          m_bits[$];
  logic [7:0]  m_data;
  bit          m_valid;
  bit          m_lock;
  logic [31:0] m_cnt;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {^(s & TAPS), s[7:1]};
  endfunction

  // First OW keystream bits produced from a seed, LSB-first.
  function automatic logic [7:0] first_word(input logic [7:0] s);
    logic [7:0] w;
    logic [7:0] r;
    r = s;
    w = '0;
    for (int i = 0; i < OW; i++) begin
      w[i] = r[0];
      r    = lfsr_next(r);
    end
    return w;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_lfsr = '0; m_bits.delete(); m_data = '0;
    m_valid = 0; m_lock = 0; m_cnt = '0;
  endtask

  task automatic model_edge();
    bit hs;
    bit can_step;
    if (reset) begin
      model_reset();
    end else if (seed_load) begin
      m_lfsr = seed; m_bits.delete(); m_valid = 0; m_cnt = '0;
      m_lock = (seed == 0);
      m_mode = (seed == 0) ? 2 : 1;
    end else begin
      hs       = m_valid && ks_ready;
      can_step = (m_mode == 1) && enable &&
                 !((m_bits.size() == OW - 1) && m_valid && !ks_ready);
      if (hs) begin
        m_valid = 0;
        if (CNT_EN) m_cnt = m_cnt + 1;
      end
      if (can_step) begin
        m_bits.push_back(m_lfsr[0]);
        m_lfsr = lfsr_next(m_lfsr);
        if (m_bits.size() == OW) begin
          for (int i = 0; i < OW; i++) m_data[i] = m_bits[i];
          m_bits.delete();
          m_valid = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(ks_valid), 32'(m_valid));
    chk({tag, "_data"},  32'(ks_data),  32'(m_data));
    chk({tag, "_lfsr"},  32'(lfsr_state), 32'(m_lfsr));
    chk({tag, "_lock"},  32'(lock_err), 32'(m_lock));
    chk({tag, "_words"}, words_out, m_cnt);
  endtask

  task automatic tick(input string tag = "cyc");
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic reseed(input logic [7:0] s);
    seed = s; seed_load = 1'b1;
    tick("seed");
    seed_load = 1'b0;
  endtask

  initial begin
    logic [7:0] held;
    reset = 1'b1; seed_load = 1'b0; seed = '0; enable = 1'b0; ks_ready = 1'b0;
    #12;
    model_reset();
    check_all("rst");
    reset = 1'b0;

    // Idle: no stepping before any seed.
    enable = 1'b1; ks_ready = 1'b1;
    repeat (3) tick("idle");

    // 1: seed 01, two words 01 and 81, lfsr 41 after 16 steps.
    reseed(8'h01);
    repeat (OW - 1) tick("t1");
    chk("t1_early_valid", 32'(ks_valid), 32'd0);
    tick("t1");
    chk("t1_w1_valid", 32'(ks_valid), 32'd1);
    chk("t1_w1_data", 32'(ks_data), 32'h01);
    repeat (OW) tick("t1");
    chk("t1_w2_data", 32'(ks_data), 32'h81);
    chk("t1_w2_valid", 32'(ks_valid), 32'd1);
    chk("t1_lfsr16", 32'(lfsr_state), 32'h41);

    // 2: backpressure after the first word freezes the last bit.
    reseed(8'h01);
    repeat (OW) tick("t2");
    ks_ready = 1'b0;
    repeat (OW + 5) tick("t2");
    chk("t2_hold_lfsr", 32'(lfsr_state), 32'h83);
    chk("t2_hold_data", 32'(ks_data), 32'h01);
    ks_ready = 1'b1;
    tick("t2");
    chk("t2_w2_data", 32'(ks_data), 32'h81);
    chk("t2_w2_valid", 32'(ks_valid), 32'd1);
    chk("t2_lfsr", 32'(lfsr_state), 32'h41);

    // 3: zero seed locks; reseed recovers.
    reseed(8'h00);
    chk("t3_lock", 32'(lock_err), 32'd1);
    chk("t3_valid", 32'(ks_valid), 32'd0);
    repeat (50) begin
      ks_ready = 1'($urandom_range(0, 1));
      tick("t3");
    end
    chk("t3_lfsr0", 32'(lfsr_state), 32'h00);
    ks_ready = 1'b1;
    reseed(8'h01);
    chk("t3_unlock", 32'(lock_err), 32'd0);
    repeat (OW) tick("t3");
    chk("t3_w1", 32'(ks_data), 32'h01);
    repeat (OW) tick("t3");
    chk("t3_w2", 32'(ks_data), 32'h81);

    // 4: reseed mid-word with a pending word discards both.
    reseed(8'h01);
    repeat (OW) tick("t4");
    ks_ready = 1'b0;
    repeat (4) tick("t4");
    chk("t4_pending", 32'(ks_valid), 32'd1);
    reseed(8'hA5);
    chk("t4_drop", 32'(ks_valid), 32'd0);
    chk("t4_lfsr", 32'(lfsr_state), 32'hA5);
    ks_ready = 1'b1;
    repeat (OW) tick("t4");
    chk("t4_word", 32'(ks_data), 32'(first_word(8'hA5)));

    // 5: enable gaps do not change the word.
    reseed(8'h5A);
    repeat (2) tick("t5");
    enable = 1'b0;
    held = lfsr_state;
    tick("t5");
    chk("t5_frz1", 32'(lfsr_state), 32'(held));
    tick("t5");
    chk("t5_frz2", 32'(lfsr_state), 32'(held));
    enable = 1'b1;
    repeat (OW - 2) tick("t5");
    chk("t5_word", 32'(ks_data), 32'(first_word(8'h5A)));
    chk("t5_valid", 32'(ks_valid), 32'd1);

    // 6: delivered-word counter.
    reseed(8'h01);
    repeat (5 * OW + 1) tick("t6");
    chk("t6_words5", words_out, CNT_EN ? 32'd5 : 32'd0);
    reseed(8'h33);
    chk("t6_clear", words_out, 32'd0);

    // Async reset mid-word loses the partial word.
    repeat (3) tick("rw");
    #2 reset = 1'b1;
    #1;
    chk("rw_async_lfsr", 32'(lfsr_state), 32'h00);
    chk("rw_async_valid", 32'(ks_valid), 32'd0);
    model_reset();
    repeat (2) tick("rw");
    #2 reset = 1'b0;
    repeat (2 * OW) tick("rw_idle");

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        seed_load = 1'b1;
        seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end else begin
        seed_load = 1'b0;
      end
      enable   = ($urandom_range(0, 3) != 0);
      ks_ready = ($urandom_range(0, 9) < 6);
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
